// File: rtl/clk1hz_timekeeper.sv
// Samples the divider's 1 Hz square wave in the clk12m domain and keeps 24-hour BCD HH:MM:SS time.
// Also provides a seconds strobe, a midnight strobe, load validation and a stalled-source watchdog.
module clk1hz_timekeeper #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 13_000_000
) (
   input  logic       clk12m,
   input  logic       reset,
   input  logic       clk1hz_in,
   input  logic       load,
   input  logic [7:0] load_hh,
   input  logic [7:0] load_mm,
   input  logic [7:0] load_ss,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       sec_tick,
   output logic       day_wrap,
   output logic       load_err,
   output logic       tick_lost
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   prev_q;
   logic                   armed_q;
   logic                   rise;
   logic [CntW-1:0]        wd_q;
   logic [CntW-1:0]        wd_d;
   logic [7:0]             hh_d;
   logic [7:0]             mm_d;
   logic [7:0]             ss_d;
   logic                   wrap_d;
   logic                   load_ok;

   function automatic logic digits_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // A tick needs a genuinely observed low first, so a line already high at reset release gives none.
   assign rise = armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;

   always_comb begin
      load_ok = digits_ok(load_hh) && digits_ok(load_mm) && digits_ok(load_ss) &&
                (load_hh <= 8'h23) && (load_mm[7:4] <= 4'd5) && (load_ss[7:4] <= 4'd5);
   end

   always_comb begin
      hh_d   = hh;
      mm_d   = mm;
      ss_d   = ss;
      wrap_d = 1'b0;
      if (rise) begin
         if (ss != 8'h59) begin
            ss_d = bcd_inc(ss);
         end else begin
            ss_d = 8'h00;
            if (mm != 8'h59) begin
               mm_d = bcd_inc(mm);
            end else begin
               mm_d = 8'h00;
               if (hh == 8'h23) begin
                  hh_d   = 8'h00;
                  wrap_d = 1'b1;
               end else begin
                  hh_d = bcd_inc(hh);
               end
            end
         end
      end
      if (load && load_ok) begin
         hh_d   = load_hh;
         mm_d   = load_mm;
         ss_d   = load_ss;
         wrap_d = 1'b0;
      end
   end

   always_comb begin
      wd_d = wd_q;
      if (rise) begin
         wd_d = '0;
      end else if (wd_q != CntMax) begin
         wd_d = wd_q + CntW'(1);
      end
   end

   always_ff @(posedge clk12m or posedge reset) begin
      if (reset) begin
         sync_q    <= '0;
         vld_q     <= '0;
         prev_q    <= 1'b0;
         armed_q   <= 1'b0;
         wd_q      <= '0;
         hh        <= 8'h00;
         mm        <= 8'h00;
         ss        <= 8'h00;
         sec_tick  <= 1'b0;
         day_wrap  <= 1'b0;
         load_err  <= 1'b0;
         tick_lost <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], clk1hz_in};
         vld_q    <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         prev_q   <= sync_q[SYNC_STAGES-1];
         armed_q  <= armed_q | (vld_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
         wd_q     <= wd_d;
         hh       <= hh_d;
         mm       <= mm_d;
         ss       <= ss_d;
         sec_tick <= rise;
         day_wrap <= wrap_d;
         load_err <= load & ~load_ok;
         if (rise) begin
            tick_lost <= 1'b0;
         end else if (wd_d == CntMax) begin
            tick_lost <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk1hz_timekeeper.sv
// Randomised bench for clk1hz_timekeeper: a seconds-of-day model and sample history predict every output
// each cycle.
module tb_clk1hz_timekeeper;

   localparam int unsigned Timeout = 40;

   logic       clk12m = 1'b0;
   logic       reset = 1'b0;
   logic       clk1hz_in = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_hh = 8'h00;
   logic [7:0] load_mm = 8'h00;
   logic [7:0] load_ss = 8'h00;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   logic       sec_tick;
   logic       day_wrap;
   logic       load_err;
   logic       tick_lost;

   clk1hz_timekeeper #(
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(Timeout)
   ) dut (
      .clk12m   (clk12m),
      .reset    (reset),
      .clk1hz_in(clk1hz_in),
      .load     (load),
      .load_hh  (load_hh),
      .load_mm  (load_mm),
      .load_ss  (load_ss),
      .hh       (hh),
      .mm       (mm),
      .ss       (ss),
      .sec_tick (sec_tick),
      .day_wrap (day_wrap),
      .load_err (load_err),
      .tick_lost(tick_lost)
   );

   always #5 clk12m = ~clk12m;

   int nvec = 0;
   int nerr = 0;

   // Reference model: input samples since reset, seconds of day, cycles since last tick.
   bit hist[$];
   int secs = 0;
   int since = 0;
   bit exp_tick = 0;
   bit exp_wrap = 0;
   bit exp_err = 0;
   int wph = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int bcd_val(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit digits_legal(input logic [7:0] b);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

   function automatic bit legal(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      return digits_legal(h) && digits_legal(m) && digits_legal(s) &&
             bcd_val(h) <= 23 && bcd_val(m) <= 59 && bcd_val(s) <= 59;
   endfunction

   // A tick lands two edges after the edge that samples high, provided the previous sample was low.
   function automatic bit tick_next();
      int n = hist.size();
      return n >= 3 && hist[n-2] && !hist[n-3];
   endfunction

   task automatic model_edge(input bit din, input bit ld, input logic [7:0] lh, input logic [7:0] lm,
                             input logic [7:0] ls);
      int n;
      hist.push_back(din);
      if (hist.size() > 4) void'(hist.pop_front());
      n = hist.size();
      exp_tick = n >= 4 && hist[n-3] && !hist[n-4];
      exp_err  = ld && !legal(lh, lm, ls);
      exp_wrap = 0;
      if (ld && legal(lh, lm, ls)) begin
         secs = bcd_val(lh) * 3600 + bcd_val(lm) * 60 + bcd_val(ls);
      end else if (exp_tick) begin
         secs = secs + 1;
         if (secs == 86400) begin
            secs = 0;
            exp_wrap = 1;
         end
      end
      if (exp_tick) since = 0;
      else if (since < Timeout) since++;
   endtask

   task automatic compare_all();
      check("hh", 32'(hh), 32'(to_bcd(secs / 3600)));
      check("mm", 32'(mm), 32'(to_bcd((secs / 60) % 60)));
      check("ss", 32'(ss), 32'(to_bcd(secs % 60)));
      check("sec_tick", 32'(sec_tick), 32'(exp_tick));
      check("day_wrap", 32'(day_wrap), 32'(exp_wrap));
      check("load_err", 32'(load_err), 32'(exp_err));
      check("tick_lost", 32'(tick_lost), 32'(since >= Timeout));
   endtask

   task automatic step(input bit din, input bit ld, input logic [7:0] lh, input logic [7:0] lm,
                       input logic [7:0] ls);
      clk1hz_in = din;
      load      = ld;
      load_hh   = lh;
      load_mm   = lm;
      load_ss   = ls;
      @(posedge clk12m);
      #1;
      model_edge(din, ld, lh, lm, ls);
      compare_all();
   endtask

   task automatic do_reset(input bit din, input int cycles);
      clk1hz_in = din;
      load      = 1'b0;
      reset     = 1'b1;
      hist.delete();
      secs     = 0;
      since    = 0;
      exp_tick = 0;
      exp_wrap = 0;
      exp_err  = 0;
      #1;
      compare_all();
      repeat (cycles) begin
         @(posedge clk12m);
         #1;
         compare_all();
      end
      reset = 1'b0;
   endtask

   task automatic wave_step(input bit ld, input logic [7:0] lh, input logic [7:0] lm,
                            input logic [7:0] ls);
      step(((wph / 10) % 2) == 1, ld, lh, lm, ls);
      wph++;
   endtask

   task automatic wave(input int n);
      repeat (n) wave_step(1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   initial begin
      bit         lvl;
      int         left;
      bit         ld;
      logic [7:0] lh;
      logic [7:0] lm;
      logic [7:0] ls;

      // Reset release with a toggling 20-cycle input.
      do_reset(1'b0, 3);
      wph = 0;
      wave(70);

      // Roll over midnight.
      wave_step(1'b1, 8'h23, 8'h59, 8'h58);
      wave(45);

      // Rejected loads leave time alone.
      wave_step(1'b1, 8'h24, 8'h00, 8'h00);
      wave(3);
      wave_step(1'b1, 8'h12, 8'h5A, 8'h00);
      wave(3);

      // Load in the same cycle as a tick.
      for (int i = 0; i < 40 && !tick_next(); i++) wave(1);
      check("s4_align", 32'(tick_next()), 32'd1);
      wave_step(1'b1, 8'h10, 8'h20, 8'h30);
      wave(25);

      // Stalled source, then recovery.
      repeat (45) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      wph = 10;
      wave(30);

      // Reset mid-period with the input high.
      wave_step(1'b1, 8'h12, 8'h34, 8'h56);
      for (int i = 0; i < 25 && ((wph / 10) % 2) == 0; i++) wave(1);
      wave(2);
      check("s6_high", 32'(clk1hz_in), 32'd1);
      do_reset(1'b1, 2);
      repeat (8) step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      wph = 0;
      wave(50);

      // Random periods, stalls, loads and resets.
      lvl  = 1'b0;
      left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (left == 0) begin
            lvl  = ~lvl;
            left = ($urandom_range(0, 30) == 0) ? int'($urandom_range(42, 60))
                                                : int'($urandom_range(2, 12));
         end
         left--;
         if ($urandom_range(0, 799) == 0) do_reset(lvl, int'($urandom_range(1, 3)));
         ld = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0: begin
               lh = 8'h23;
               lm = 8'h59;
               ls = to_bcd(int'($urandom_range(50, 59)));
            end
            1: begin
               lh = to_bcd(int'($urandom_range(0, 23)));
               lm = to_bcd(int'($urandom_range(0, 59)));
               ls = to_bcd(int'($urandom_range(0, 59)));
            end
            default: begin
               lh = 8'($urandom);
               lm = 8'($urandom);
               ls = 8'($urandom);
            end
         endcase
         step(lvl, ld, lh, lm, ls);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
